// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: arbiter slot encoding and framebuffer geometry.
package fb_pkg;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_RD   = 2'd1,
        SLOT_WR   = 2'd2
    } slot_e;

    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 2;
    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int FB_WORDS  = FB_WIDTH * FB_HEIGHT;

    // Pointer index width for a power-of-two FIFO depth (wrap bit added by the user).
    function automatic int fifo_idx_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous write FIFO with wrap-bit pointers and registered full/empty flags.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int W     = FB_ADDR_W + FB_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = fifo_idx_w(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic         full_q, full_d;
    logic         empty_q, empty_d;
    logic         push_ok, pop_ok;

    assign push_ok = push && !full_q;
    assign pop_ok  = pop && !empty_q;

    // Flags are computed from the next-state pointers so they are exact the cycle after the update.
    always_comb begin
        wptr_d  = wptr_q + {{AW{1'b0}}, push_ok};
        rptr_d  = rptr_q + {{AW{1'b0}}, pop_ok};
        full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
        empty_d = (wptr_d == rptr_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q[AW-1:0]] <= push_data;
        end
    end

    assign head_data = mem_q[rptr_q[AW-1:0]];
    assign full      = full_q;
    assign empty     = empty_q;

endmodule

// File: rtl/framebuffer_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads always win, buffered writes retire in free slots.
// Optional writer stall counter (wr_stall_cnt) is built when FB_ARB_STATS_EN is defined.
module framebuffer_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = FB_DATA_W,
    parameter int WBUF_DEPTH = 4
) (
    input  logic              vga_clk_25,
    input  logic              reset_n,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]       wr_stall_cnt
`endif
);

    localparam int EW = ADDR_W + DATA_W;

    logic [EW-1:0]     head;
    logic              fifo_full, fifo_empty;
    logic              pop;

    slot_e             slot_q, slot_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        rd_pending_q, rd_pending_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    fb_wr_fifo #(
        .W     (EW),
        .DEPTH (WBUF_DEPTH)
    ) u_wr_fifo (
        .clk       (vga_clk_25),
        .rst_n     (reset_n),
        .push      (wr_valid),
        .push_data ({wr_addr, wr_data}),
        .pop       (pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Slot choice uses the registered empty flag, so a fresh push waits one cycle before retiring.
    always_comb begin
        slot_d      = SLOT_IDLE;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        pop         = 1'b0;
        if (rd_en) begin
            slot_d     = SLOT_RD;
            mem_addr_d = rd_addr;
        end else if (!fifo_empty) begin
            slot_d      = SLOT_WR;
            pop         = 1'b1;
            mem_addr_d  = head[EW-1:DATA_W];
            mem_wdata_d = head[DATA_W-1:0];
        end
        rd_pending_d = {rd_pending_q[0], rd_en};
        rd_data_d    = rd_pending_q[1] ? mem_rdata : '0;
    end

    always_ff @(posedge vga_clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            slot_q       <= SLOT_IDLE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rd_pending_q <= '0;
            rd_data_q    <= '0;
        end else begin
            slot_q       <= slot_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            rd_pending_q <= rd_pending_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign mem_we    = (slot_q == SLOT_WR);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rd_data   = rd_data_q;
    assign wr_ready  = !fifo_full;

`ifdef FB_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (wr_valid && !wr_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge vga_clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign wr_stall_cnt = stall_cnt_q;
`else
    // Stall statistics are not built in this configuration.
`endif

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter with a behavioural single-port RAM.
module tb_framebuffer_arbiter;
    import fb_pkg::*;

    localparam int AW = FB_ADDR_W;
    localparam int DW = FB_DATA_W;
    localparam int EW = AW + DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_en, wr_valid, wr_ready, mem_we;
    logic [AW-1:0] rd_addr, wr_addr, mem_addr;
    logic [DW-1:0] rd_data, wr_data, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
`ifdef FB_ARB_STATS_EN
    logic [15:0]   wr_stall_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_q[$];
    logic [DW-1:0] ram [int];

    framebuffer_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .WBUF_DEPTH (4)
    ) dut (
        .vga_clk_25 (clk),
        .reset_n    (rst_n),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef FB_ARB_STATS_EN
        ,
        .wr_stall_cnt (wr_stall_cnt)
`endif
    );

    // 25 MHz pixel clock
    always #20 clk = ~clk;

    // Unwritten RAM words read back as addr[1:0].
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            ram[int'(mem_addr)] = mem_wdata;
        end else begin
            mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : mem_addr[1:0];
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) begin
            got_q.push_back({mem_addr, mem_wdata});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            chk({tag, "_order"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        rst_n    = 1'b0;
        rd_en    = 1'b0;
        wr_valid = 1'b0;
        rd_addr  = '0;
        wr_addr  = '0;
        wr_data  = '0;

        // reset state
        tick();
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_wr_ready", 32'(wr_ready), 32'h1);
`ifdef FB_ARB_STATS_EN
        chk("rst_stall_cnt", 32'(wr_stall_cnt), 32'h0);
`endif
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_mem_we", 32'(mem_we), 32'h0);
            chk("idle_wr_ready", 32'(wr_ready), 32'h1);
        end

        // scan-out reads 0..9: rd_data follows two cycles behind
        for (int i = 0; i < 13; i++) begin
            rd_en   = (i < 10);
            rd_addr = AW'(i);
            tick();
            chk("rd_mem_we", 32'(mem_we), 32'h0);
            chk("rd_data", 32'(rd_data), (i >= 2 && i < 12) ? 32'((i - 2) % 4) : 32'h0);
        end

        // writes under continuous reads: four fit, fifth waits
        rd_en    = 1'b1;
        rd_addr  = AW'(17'h00010);
        wr_valid = 1'b1;
        wr_data  = 2'd3;
        for (int k = 0; k < 4; k++) begin
            wr_addr = AW'(17'h00100 + k);
            chk("fill_wr_ready", 32'(wr_ready), 32'h1);
            exp_q.push_back({wr_addr, wr_data});
            tick();
            chk("fill_mem_we", 32'(mem_we), 32'h0);
        end
        wr_addr = AW'(17'h00104);
        for (int k = 0; k < 3; k++) begin
            chk("full_wr_ready", 32'(wr_ready), 32'h0);
            tick();
            chk("full_mem_we", 32'(mem_we), 32'h0);
        end
        rd_en = 1'b0;
        tick();
        chk("drain_first_we", 32'(mem_we), 32'h1);
        chk("drain_wr_ready", 32'(wr_ready), 32'h1);
        exp_q.push_back({wr_addr, wr_data});
        tick();
        wr_valid = 1'b0;
        repeat (3) tick();
        chk("drain_last_we", 32'(mem_we), 32'h1);
        tick();
        chk("drain_done_we", 32'(mem_we), 32'h0);
        check_writes("drain");

        // read and write to the same word in one cycle: read sees the old value
        rd_en    = 1'b1;
        rd_addr  = AW'(17'h00050);
        wr_valid = 1'b1;
        wr_addr  = AW'(17'h00050);
        wr_data  = 2'd2;
        chk("tear_wr_ready", 32'(wr_ready), 32'h1);
        exp_q.push_back({wr_addr, wr_data});
        tick();
        rd_en    = 1'b0;
        wr_valid = 1'b0;
        tick();
        chk("tear_mem_we", 32'(mem_we), 32'h1);
        chk("tear_mem_addr", 32'(mem_addr), 32'h00050);
        chk("tear_mem_wdata", 32'(mem_wdata), 32'h2);
        tick();
        chk("tear_old_data", 32'(rd_data), 32'h0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        tick();
        chk("tear_new_data", 32'(rd_data), 32'h2);
        tick();
        check_writes("tear");

        // steady push+pop at occupancy 2
        rd_en    = 1'b1;
        wr_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wr_addr = AW'(17'h00200 + k);
            wr_data = DW'(k);
            exp_q.push_back({wr_addr, wr_data});
            tick();
        end
        rd_en = 1'b0;
        for (int k = 2; k < 22; k++) begin
            wr_addr = AW'(17'h00200 + k);
            wr_data = DW'(k);
            exp_q.push_back({wr_addr, wr_data});
            tick();
            chk("pp_wr_ready", 32'(wr_ready), 32'h1);
            chk("pp_mem_we", 32'(mem_we), 32'h1);
        end
        wr_valid = 1'b0;
        tick();
        chk("pp_tail1_we", 32'(mem_we), 32'h1);
        tick();
        chk("pp_tail2_we", 32'(mem_we), 32'h1);
        tick();
        chk("pp_empty_we", 32'(mem_we), 32'h0);
        check_writes("pp");

        // starvation under continuous reads, then asynchronous reset mid-run
        #5 rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        rd_en    = 1'b1;
        rd_addr  = AW'(17'h01234);
        wr_valid = 1'b1;
        wr_addr  = AW'(17'h00300);
        wr_data  = 2'd1;
`ifdef FB_ARB_STATS_EN
        repeat (104) tick();
        chk("stall_cnt_100", 32'(wr_stall_cnt), 32'd100);
        repeat (70000 - 104) tick();
        chk("stall_cnt_sat", 32'(wr_stall_cnt), 32'hFFFF);
`else
        repeat (8) tick();
`endif
        chk("starve_wr_ready", 32'(wr_ready), 32'h0);
        chk("starve_mem_addr", 32'(mem_addr), 32'h01234);
        #5 rst_n = 1'b0;
        #1;
        chk("arst_wr_ready", 32'(wr_ready), 32'h1);
        chk("arst_mem_we", 32'(mem_we), 32'h0);
        chk("arst_mem_addr", 32'(mem_addr), 32'h0);
        chk("arst_rd_data", 32'(rd_data), 32'h0);
`ifdef FB_ARB_STATS_EN
        chk("arst_stall_cnt", 32'(wr_stall_cnt), 32'h0);
`endif
        rd_en    = 1'b0;
        wr_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_mem_we", 32'(mem_we), 32'h0);
        end
        check_writes("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/framebuffer_arbiter.md
# framebuffer_arbiter

Shares the single-port framebuffer RAM between the VGA scan-out read path and a pixel writer (camera/capture path), all in the 25 MHz pixel clock domain. VGA reads always win, so scan-out sees a fixed two-cycle read latency with no stalls. Writes are absorbed by a small FIFO and retired in cycles where no read is requested, mainly horizontal and vertical blanking. The block sits between `vga_controller` (addr/din) and the framebuffer RAM macro.

## Interface
- `ADDR_W`, 17: framebuffer address width (320x240 = 76800 words).
- `DATA_W`, 2: pixel width.
- `WBUF_DEPTH`, 4: write FIFO depth; must be a power of two, 2..16.

Ports:
- `vga_clk_25`  in  1  pixel clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rd_en`  in  1  scan-out read request for this cycle (active video).
- `rd_addr`  in  ADDR_W  scan-out read address.
- `rd_data`  out  DATA_W  read pixel, two cycles after the request.
- `wr_valid`  in  1  write request.
- `wr_addr`  in  ADDR_W  write address.
- `wr_data`  in  DATA_W  write pixel.
- `wr_ready`  out  1  write FIFO not full.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_we`  out  1  RAM write enable.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_rdata`  in  DATA_W  RAM read data, valid one cycle after `mem_addr` with `mem_we`=0.
- `wr_stall_cnt`  out  16  writer stall counter; present only with `FB_ARB_STATS_EN`.

## Operation
- Write FIFO:
  - A write is accepted on a cycle with `wr_valid && wr_ready`.
  - `wr_ready` = !full. It is registered and derived from the next-state count.
  - Writes retire in order.
- Slot arbiter: one RAM access per cycle, selected by registered state `slot`:
  - `SLOT_RD` when `rd_en`=1, regardless of FIFO state. Drives `mem_addr`=`rd_addr`, `mem_we`=0.
  - `SLOT_WR` when `rd_en`=0 and the FIFO is non-empty. Pops the head and drives `mem_addr`/`mem_wdata` from it, `mem_we`=1.
  - `SLOT_IDLE` otherwise. Drives `mem_we`=0 and holds `mem_addr`.
- The RAM interface outputs (`mem_addr`, `mem_we`, `mem_wdata`) are registered.
- Read return:
  - A two-stage `rd_pending` pipeline tracks `SLOT_RD` slots.
  - `rd_data` is registered from `mem_rdata` when the tag is set, and is 0 otherwise.
- No forwarding: a read hitting a buffered, not-yet-retired write returns the old RAM contents. This tearing is accepted.
- Simultaneous push and pop in the same cycle: the count is unchanged. A push when full is refused. A push when empty becomes eligible for `SLOT_WR` in the next cycle, not the same one.
- Pointers are log2(WBUF_DEPTH) bits plus 1 wrap bit. Full = MSBs differ and LSBs are equal.
- Reset, asserted asynchronously at any time:
  - FIFO is emptied and pointers are cleared.
  - `slot`=`SLOT_IDLE`, `rd_pending`=0.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `rd_data`=0.
  - `wr_ready`=1, `wr_stall_cnt`=0.
  - Any in-flight write is lost. Deassertion is the only synchronous event.

## Timing
- Read latency: `rd_en`/`rd_addr` sampled at edge N, `mem_addr` valid after N, `mem_rdata` at N+1, `rd_data` valid after N+2. The latency is fixed at 2 cycles.
- Write latency: a write accepted at edge N reaches `mem_we` no earlier than after edge N+1, when `rd_en`=0 at N+1.
- Starvation: with `rd_en` high continuously, the FIFO fills and `wr_ready` drops. Each 800-clock line gives 160 free slots, which is enough to drain a full FIFO.
- Throughput: one write per cycle in blanking.

## Configuration
- `FB_ARB_STATS_EN` defined:
  - Adds the `wr_stall_cnt` port.
  - The counter increments on each cycle with `wr_valid && !wr_ready`, saturates at 16'hFFFF, and clears only on reset.
- `FB_ARB_STATS_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `fb_pkg`:
  - slot encoding `SLOT_IDLE`/`SLOT_RD`/`SLOT_WR`
  - `FB_ADDR_W`=17, `FB_DATA_W`=2
  - `FB_WIDTH`=320, `FB_HEIGHT`=240
- One sub-module: `fb_wr_fifo`, a synchronous FIFO with a registered `full`/`empty` and the push/pop interface. The arbiter, read pipeline and stats counter live in the top level.

## Test plan
- Reset with `rd_en`=0, `wr_valid`=0 -> all outputs 0 except `wr_ready`=1. `mem_we` stays 0 for 10 cycles.
- `rd_en`=1 with `rd_addr` 0..9 and a RAM model holding addr[1:0] -> `rd_data` shows 0,1,2,3,0… starting exactly 2 cycles after the first request. `mem_we` is never 1.
- `rd_en`=1 held while writing 5 pixels (0x00100..0x00104, data 3) -> 4 are accepted, then `wr_ready`=0. Each of the 5 writes is driven to `mem_we` within 5 cycles after `rd_en` drops.
- Write 0x00050<-2 and read 0x00050 in the same cycle while the FIFO is empty -> the read returns the old value (0). A read issued after the write retires returns 2.
- Push and pop in the same cycle at count 2 for 20 cycles -> the count stays 2, `wr_ready` stays 1, and write order is preserved.
- With `FB_ARB_STATS_EN`: keep the FIFO full under `rd_en`=1 with `wr_valid`=1 for 70000 cycles -> `wr_stall_cnt` saturates at 0xFFFF. A mid-test `reset_n` pulse clears it and the FIFO asynchronously.
